// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory between the pipeline MEM stage (P port) and
// a secondary burst requester such as a debug loader or DMA engine (D port).
// P has priority every cycle. D beats go into idle slots. A starvation counter
// takes one slot from P after STARVE_MAX consecutive denied cycles, and stalls
// the pipeline for that one cycle.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset (0 = reset)
//   p_valid/p_we         MEM stage op valid / op is a store
//   p_addr/p_wdata       MEM stage byte address / store data
//   p_rdata              load data (always m_rdata)
//   p_stall              slot taken by D; MEM stage holds its op and retries
//   d_req/d_we           D command valid / burst is a write
//   d_addr/d_len         D word-aligned start address / beats minus one
//   d_ready              D command accepted when d_req & d_ready
//   d_wdata/d_wready     D write word / word consumed this cycle
//   d_rvalid/d_rdata     registered D read word
//   d_done               one-cycle burst-complete pulse
//   m_we/m_addr/m_wdata  memory write enable / byte address / write data
//   m_rdata              combinational memory read data
//   dbg_state            current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshakes: a D command transfers in a cycle where d_req and d_ready are both
// high. The accept cycle performs no memory access. A write word on d_wdata
// must stay stable until a cycle with d_wready high, and is consumed in that
// cycle. d_rvalid is a one-cycle qualifier with no back-pressure.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DBITS      = 32,
  parameter int LENBITS    = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_valid,
  input  logic               p_we,
  input  logic [DBITS-1:0]   p_addr,
  input  logic [DBITS-1:0]   p_wdata,
  output logic [DBITS-1:0]   p_rdata,
  output logic               p_stall,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DBITS-1:0]   d_addr,
  input  logic [LENBITS-1:0] d_len,
  output logic               d_ready,
  input  logic [DBITS-1:0]   d_wdata,
  output logic               d_wready,
  output logic               d_rvalid,
  output logic [DBITS-1:0]   d_rdata,
  output logic               d_done,
  output logic               m_we,
  output logic [DBITS-1:0]   m_addr,
  output logic [DBITS-1:0]   m_wdata,
  input  logic [DBITS-1:0]   m_rdata,
  output logic               dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam int BW = LENBITS + 1;  // holds d_len+1 without overflow

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [BW-1:0]    beats_q, beats_d;
  logic [DBITS-1:0] cur_addr_q, cur_addr_d;
  logic             we_l_q, we_l_d;
  logic [DBITS-1:0] d_rdata_q, d_rdata_d;
  logic             d_rvalid_q, d_rvalid_d;
  logic             d_done_q, d_done_d;

  logic busy;
  logic starved;
  logic d_slot;

  assign busy    = (state_q == BUSY);
  assign starved = (starve_q == STARVE_TOP);
  // D takes the slot when P is idle, or when D has waited long enough.
  assign d_slot  = busy & (~p_valid | starved);

  // Memory-side mux. When D steals the slot, P's store never reaches m_we.
  assign m_addr   = d_slot ? cur_addr_q : p_addr;
  assign m_we     = d_slot ? we_l_q : (p_valid & p_we);
  assign m_wdata  = (d_slot & we_l_q) ? d_wdata : p_wdata;
  assign d_wready = d_slot & we_l_q;
  assign p_stall  = busy & p_valid & starved;
  assign d_ready  = ~busy;
  assign p_rdata  = m_rdata;

  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    beats_d    = beats_q;
    cur_addr_d = cur_addr_q;
    we_l_d     = we_l_q;
    d_rdata_d  = d_rdata_q;
    d_rvalid_d = 1'b0;
    d_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (d_req) begin
          cur_addr_d = d_addr;
          beats_d    = {1'b0, d_len} + BW'(1);
          we_l_d     = d_we;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (d_slot) begin
          cur_addr_d = cur_addr_q + DBITS'(4);  // wraps modulo 2^DBITS
          beats_d    = beats_q - BW'(1);
          starve_d   = '0;
          if (!we_l_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_rdata;
          end
          if (beats_q == BW'(1)) begin
            state_d  = IDLE;
            d_done_d = 1'b1;
          end
        end else if (p_valid && !starved) begin
          starve_d = starve_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      beats_q    <= '0;
      cur_addr_q <= '0;
      we_l_q     <= 1'b0;
      d_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      beats_q    <= beats_d;
      cur_addr_q <= cur_addr_d;
      we_l_q     <= we_l_d;
      d_rdata_q  <= d_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_done_q   <= d_done_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed test of dmem_arbiter with DBITS=32, LENBITS=4, STARVE_MAX=4.
// The bench owns a small behavioural data memory (256 words, combinational
// read, clocked write), preloaded with pat(i) = 0xA5000000 | i.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        p_valid, p_we;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_stall;
  logic        d_req, d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_len;
  logic        d_ready;
  logic [31:0] d_wdata;
  logic        d_wready, d_rvalid;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        dbg_state;

  dmem_arbiter #(.DBITS(32), .LENBITS(4), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
    .d_ready(d_ready), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  logic        mem_ready;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
  end
  assign m_rdata = mem[m_addr[9:2]];

  // ---------------- scoreboard ----------------
  logic [31:0] rd_exp_q[$];    // expected d_rdata words in order
  logic [63:0] wr_exp_q[$];    // expected {m_addr, m_wdata} per write
  logic [0:0]  done_exp_q[$];  // one token per expected d_done pulse
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a memory write,
  // a read word or a done pulse.
  always @(negedge clk) begin
    if (m_we === 1'b1) begin
      if (wr_exp_q.size() == 0) chk("unexpected_write", {m_addr, m_wdata}, 64'h0);
      else chk("mem_write", {m_addr, m_wdata}, wr_exp_q.pop_front());
    end
    if (d_rvalid === 1'b1) begin
      if (rd_exp_q.size() == 0) chk("unexpected_rvalid", {32'h0, d_rdata}, 64'h0);
      else chk("d_rdata", {32'h0, d_rdata}, {32'h0, rd_exp_q.pop_front()});
    end
    if (d_done === 1'b1) begin
      if (done_exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else void'(done_exp_q.pop_front());
    end
  end

  // ---------------- driver helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p_valid = 1'b0; p_we = 1'b0; p_addr = 32'h300; p_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_len = 4'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    d_wdata = 32'h0;
    idle_inputs();
    nxt();
    mem_ready = 1'b1;
    nxt();
    // Reset state
    mid();
    chk("rst_d_ready", {63'h0, d_ready}, 64'd1);
    chk("rst_d_rvalid", {63'h0, d_rvalid}, 64'd0);
    chk("rst_d_done", {63'h0, d_done}, 64'd0);
    chk("rst_p_stall", {63'h0, p_stall}, 64'd0);
    chk("rst_m_we", {63'h0, m_we}, 64'd0);
    chk("rst_m_addr", {32'h0, m_addr}, 64'h300);
    chk("rst_state", {63'h0, dbg_state}, 64'd0);
    nxt();
    reset = 1'b1;
    nxt();

    // P store then load with D idle
    p_valid = 1'b1; p_we = 1'b1; p_addr = 32'h20; p_wdata = 32'hDEADBEEF;
    wr_exp_q.push_back({32'h20, 32'hDEADBEEF});
    mid();
    chk("pst_m_we", {63'h0, m_we}, 64'd1);
    chk("pst_stall", {63'h0, p_stall}, 64'd0);
    nxt();
    p_we = 1'b0;
    mid();
    chk("pld_rdata", {32'h0, p_rdata}, 64'hDEADBEEF);
    chk("pld_m_we", {63'h0, m_we}, 64'd0);
    chk("pld_stall", {63'h0, p_stall}, 64'd0);
    nxt();
    idle_inputs();
    nxt();

    // D read burst 0x100, len 3, P idle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_len = 4'd3;
    for (int i = 0; i < 4; i++) rd_exp_q.push_back(pat(64 + i));
    done_exp_q.push_back(1'b1);
    mid();
    chk("rd_accept_ready", {63'h0, d_ready}, 64'd1);
    nxt();
    d_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mid();
      chk("rd_m_addr", {32'h0, m_addr}, 64'(32'h100 + 32'(4 * (k - 1))));
      chk("rd_m_we", {63'h0, m_we}, 64'd0);
      chk("rd_done_early", {63'h0, d_done}, 64'd0);
      nxt();
    end
    mid();
    chk("rd_done_n5", {63'h0, d_done}, 64'd1);
    chk("rd_rvalid_n5", {63'h0, d_rvalid}, 64'd1);
    chk("rd_ready_back", {63'h0, d_ready}, 64'd1);
    nxt();
    mid();
    chk("rd_done_n6", {63'h0, d_done}, 64'd0);
    nxt();

    // Wrap-around read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFFFF_FFFC; d_len = 4'd1;
    rd_exp_q.push_back(pat(255));
    rd_exp_q.push_back(pat(0));
    done_exp_q.push_back(1'b1);
    nxt();
    d_req = 1'b0;
    mid();
    chk("wrap_addr0", {32'h0, m_addr}, 64'hFFFF_FFFC);
    nxt();
    mid();
    chk("wrap_addr1", {32'h0, m_addr}, 64'h0);
    nxt();
    nxt();

    // Starvation: P loads held, D write of 2 beats to 0x40
    p_valid = 1'b1; p_we = 1'b0; p_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_len = 4'd1;
    d_wdata = 32'h1111_0000;
    wr_exp_q.push_back({32'h40, 32'h1111_0000});
    wr_exp_q.push_back({32'h44, 32'h2222_0000});
    done_exp_q.push_back(1'b1);
    mid();
    chk("st_accept_ready", {63'h0, d_ready}, 64'd1);
    chk("st_accept_stall", {63'h0, p_stall}, 64'd0);
    nxt();
    d_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      mid();
      if (k == 5 || k == 10) begin
        chk("st_stall", {63'h0, p_stall}, 64'd1);
        chk("st_m_we", {63'h0, m_we}, 64'd1);
        chk("st_wready", {63'h0, d_wready}, 64'd1);
        chk("st_m_addr", {32'h0, m_addr}, (k == 5) ? 64'h40 : 64'h44);
      end else begin
        chk("st_no_stall", {63'h0, p_stall}, 64'd0);
        chk("st_p_addr", {32'h0, m_addr}, 64'h300);
        chk("st_p_done", {63'h0, d_done}, 64'd0);
      end
      nxt();
      if (k == 5) d_wdata = 32'h2222_0000;
    end
    mid();
    chk("st_done", {63'h0, d_done}, 64'd1);
    chk("st_done_stall", {63'h0, p_stall}, 64'd0);
    nxt();
    idle_inputs();
    nxt();

    // Single-beat read with a d_req pulse while BUSY
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; d_len = 4'd0;
    rd_exp_q.push_back(pat(96));
    done_exp_q.push_back(1'b1);
    nxt();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1C0; d_len = 4'd3;
    mid();
    chk("sb_busy_ready", {63'h0, d_ready}, 64'd0);
    chk("sb_m_addr", {32'h0, m_addr}, 64'h180);
    nxt();
    d_req = 1'b0;
    mid();
    chk("sb_done", {63'h0, d_done}, 64'd1);
    chk("sb_rvalid", {63'h0, d_rvalid}, 64'd1);
    chk("sb_ready", {63'h0, d_ready}, 64'd1);
    nxt();
    mid();
    chk("sb_done_gone", {63'h0, d_done}, 64'd0);
    chk("sb_rvalid_gone", {63'h0, d_rvalid}, 64'd0);
    chk("sb_no_write", {63'h0, m_we}, 64'd0);
    nxt();
    idle_inputs();
    nxt();

    // Reset mid-burst: 8-beat write to 0x200, reset after 2 beats
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_len = 4'd7;
    d_wdata = 32'h5A5A_0000;
    wr_exp_q.push_back({32'h200, 32'h5A5A_0000});
    wr_exp_q.push_back({32'h204, 32'h5A5A_0001});
    nxt();
    d_req = 1'b0;
    mid();
    chk("rm_wready0", {63'h0, d_wready}, 64'd1);
    nxt();
    d_wdata = 32'h5A5A_0001;
    mid();
    chk("rm_addr1", {32'h0, m_addr}, 64'h204);
    nxt();
    reset = 1'b0;
    p_valid = 1'b1; p_we = 1'b0; p_addr = 32'h300;
    #1;
    chk("rm_rvalid", {63'h0, d_rvalid}, 64'd0);
    chk("rm_done", {63'h0, d_done}, 64'd0);
    chk("rm_stall", {63'h0, p_stall}, 64'd0);
    chk("rm_ready", {63'h0, d_ready}, 64'd1);
    chk("rm_m_we", {63'h0, m_we}, 64'd0);
    chk("rm_m_addr", {32'h0, m_addr}, 64'h300);
    nxt();
    nxt();
    reset = 1'b1;
    p_valid = 1'b0;
    for (int k = 0; k < 10; k++) nxt();
    chk("rm_mem0", {32'h0, mem[128]}, 64'h5A5A_0000);
    chk("rm_mem1", {32'h0, mem[129]}, 64'h5A5A_0001);
    for (int i = 2; i < 8; i++) chk("rm_mem_kept", {32'h0, mem[128 + i]}, {32'h0, pat(128 + i)});
    chk("rm_state", {63'h0, dbg_state}, 64'd0);

    // All expectations consumed
    chk("rd_q_empty", 64'(rd_exp_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_exp_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter that shares the D-MEM array between the pipeline MEM stage and a secondary burst requester (debug loader / DMA). The MEM stage has priority every cycle. The secondary port is served in idle slots, and a starvation counter periodically steals one slot by stalling the pipeline. It sits between the MEM stage's memory address/data signals and the `dmem` array, which keeps its combinational read and clocked write.

## Interface
- `DBITS`, 32, data and address width.
- `LENBITS`, 4, burst-length field width; a burst is `d_len`+1 words.
- `STARVE_MAX`, 4, consecutive denied cycles before the D port wins a slot; must be ≥1.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `p_valid` in 1: the MEM stage has a memory op this cycle.
- `p_we` in 1: the MEM op is a store.
- `p_addr` in DBITS: MEM byte address.
- `p_wdata` in DBITS: MEM store data.
- `p_rdata` out DBITS: load data, equal to `m_rdata`.
- `p_stall` out 1: the slot was taken by the D port; the MEM stage must hold its op and retry.
- `d_req` in 1: D command valid.
- `d_we` in 1: the D burst is a write.
- `d_addr` in DBITS: D start byte address, word aligned.
- `d_len` in LENBITS: D burst length minus one.
- `d_ready` out 1: command accepted when `d_req` & `d_ready`.
- `d_wdata` in DBITS: current write word, held until `d_wready`.
- `d_wready` out 1: `d_wdata` is consumed this cycle.
- `d_rvalid` out 1: `d_rdata` is valid.
- `d_rdata` out DBITS: registered read word.
- `d_done` out 1: one-cycle burst-complete pulse.
- `m_we` out 1: memory write enable.
- `m_addr` out DBITS: memory byte address.
- `m_wdata` out DBITS: memory write data.
- `m_rdata` in DBITS: combinational memory read data.

## Operation
- FSM states:
  - IDLE: `d_ready`=1. On `d_req`, latch `cur_addr`=`d_addr`, `beats`=`d_len`+1 and `we_l`=`d_we`, then go to BUSY. The accept cycle performs no D memory access.
  - BUSY: `d_ready`=0; `d_req` is ignored.
- Slot owner each cycle:
  - D owns the slot when in BUSY & (!`p_valid` | `starve`==STARVE_MAX).
  - Otherwise P owns it.
- P owns the slot:
  - `m_addr`=`p_addr`, `m_we`=`p_valid`&`p_we`, `m_wdata`=`p_wdata`.
- D owns the slot:
  - `m_addr`=`cur_addr`.
  - If `we_l`: `m_we`=1, `m_wdata`=`d_wdata`, `d_wready`=1.
  - Else: `m_we`=0, and `d_rdata` <= `m_rdata` with `d_rvalid` set next cycle.
  - `cur_addr` += 4, modulo 2^DBITS (wraps).
  - `beats` -= 1. On the last beat, go to IDLE and set `d_done` next cycle.
- `p_stall` = BUSY & `p_valid` & `starve`==STARVE_MAX. When `p_stall` is high, P must not reach `m_we`.
- Starvation counter `starve`:
  - In BUSY, increments on each cycle P owns the slot with `p_valid`=1, saturating at STARVE_MAX.
  - Clears to 0 on every D beat and in IDLE.
- `p_rdata` = `m_rdata` always. It is meaningful only when P owns the slot.
- Reset asserted (at any time, including mid-burst):
  - State goes to IDLE; `starve`, `beats`, `cur_addr`, `d_rdata`, `d_rvalid` and `d_done` go to 0.
  - The burst is abandoned and no `d_done` pulse is produced.
  - Memory contents are untouched.
- Output values during reset: `d_ready`=1; `p_stall`, `d_wready` and `m_we` are 0 unless P drives a store; `m_addr`=`p_addr`.

## Timing
- `d_ready`, `p_stall`, `d_wready`, `m_*` and `p_rdata` are combinational.
- `d_rvalid`, `d_rdata` and `d_done` are registered.
- Accept in cycle N; first D beat is in cycle N+1 at the earliest.
- Read latency: `d_rvalid` is asserted 1 cycle after the D beat.
- `d_done` is asserted in the cycle after the last beat, coincident with the last `d_rvalid` on reads.
- Throughput is 1 beat/cycle when `p_valid`=0.
- Worst-case gap between D beats is STARVE_MAX+1 cycles.
- A P op stalls for at most 1 consecutive cycle, because `starve` clears on the stolen slot.
- Next command: `d_ready` returns the cycle after the last beat; back-to-back bursts have a 1-cycle accept bubble.

## Test plan
- D read burst, `d_addr`=0x100, `d_len`=3, `p_valid`=0:
  - `m_addr` is 0x100, 0x104, 0x108, 0x10C in cycles N+1..N+4.
  - `d_rvalid` is asserted in N+2..N+5 with the memory words.
  - `d_done` is asserted in N+5 only.
- `p_valid` held 1 and STARVE_MAX=4, D write `d_len`=1 to 0x40:
  - P is served 4 cycles.
  - Cycle 5: `p_stall`=1, `m_we`=1, `m_addr`=0x40.
  - 4 more P cycles, then a stall writes 0x44.
  - `d_done` follows the second write.
- D idle, P store 0xDEADBEEF to 0x20 then load 0x20:
  - `m_we` pulses with the store.
  - `p_rdata`=0xDEADBEEF on the load.
  - `p_stall` stays 0 throughout.
- Wrap: `d_addr`=0xFFFFFFFC, `d_len`=1, read:
  - Beat addresses are 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: `reset`=0 after 2 of 8 write beats:
  - `d_rvalid`, `d_done` and `p_stall` are 0 immediately.
  - `d_ready`=1.
  - No further `m_we` from D after release.
  - Memory words 2..7 are unchanged.
- `d_req` pulsed during BUSY, plus a single-beat burst (`d_len`=0):
  - The command issued during BUSY is ignored.
  - The single-beat burst performs exactly one beat, with `d_done` one cycle later.
